// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths, load/store mode encodings and byte-lane helper.
package mips_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;

   localparam logic [1:0] LM_WORD  = 2'b00;
   localparam logic [1:0] LM_HALF  = 2'b01;
   localparam logic [1:0] LM_BYTE  = 2'b10;
   localparam logic [1:0] LM_UBYTE = 2'b11;

   // Little-endian lane enables; halfword ignores addr[0], word ignores addr[1:0].
   function automatic logic [3:0] lane_we(input logic [1:0] mode, input logic [1:0] addr);
      logic [3:0] we;
      case (mode)
         LM_WORD: we = 4'b1111;
         LM_HALF: we = addr[1] ? 4'b1100 : 4'b0011;
         default: we = 4'b0001 << addr;
      endcase
      return we;
   endfunction

endpackage

// File: rtl/data_mem.sv
// DEPTH x 32 data memory: four byte-lane write enables, asynchronous read, no reset.
module data_mem
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              CLK,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: sized loads/stores, branch resolution, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ex_mem_zero,
   input  logic              ex_mem_branch,
   input  logic              ex_mem_reg_write,
   input  logic              ex_mem_mem_write,
   input  logic              ex_mem_mem_read,
   input  logic              ex_mem_mem_to_reg,
   input  logic [1:0]        ex_mem_load_mode,
   input  logic [REG_W-1:0]  ex_mem_dest,
   input  logic [DATA_W-1:0] ex_mem_alu_result,
   input  logic [DATA_W-1:0] ex_mem_rt,
   input  logic [DATA_W-1:0] ex_mem_pc,
   output logic              mem_if_pc_src,
   output logic [DATA_W-1:0] mem_if_pc,
   output logic              mem_wb_reg_write,
   output logic              mem_wb_mem_to_reg,
   output logic [1:0]        mem_wb_load_mode,
   output logic [REG_W-1:0]  mem_wb_dest,
   output logic [DATA_W-1:0] mem_wb_read_data,
   output logic [DATA_W-1:0] mem_wb_alu_result
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   ,
   output logic              mem_misalign_err
`endif
);

   logic [1:0]        lane;
   logic [ADDR_W-1:0] word_idx;
   logic [3:0]        we;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] load_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic              store_ok;
   logic              load_ok;
   logic              wb_reg_write;
   logic              unused_addr_hi;

   assign lane           = ex_mem_alu_result[1:0];
   assign word_idx       = ex_mem_alu_result[ADDR_W+1:2];
   assign unused_addr_hi = ^ex_mem_alu_result[DATA_W-1:ADDR_W+2];

   assign mem_if_pc_src = ex_mem_branch & ex_mem_zero;
   assign mem_if_pc     = ex_mem_pc;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic misalign;

   assign misalign = ((ex_mem_load_mode == LM_HALF) && lane[0]) ||
                     ((ex_mem_load_mode == LM_WORD) && (lane != 2'b00));
   assign store_ok     = ex_mem_mem_write & ~misalign;
   assign load_ok      = ex_mem_mem_read & ~misalign;
   assign wb_reg_write = ex_mem_reg_write & ~(ex_mem_mem_read & misalign);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                              mem_misalign_err <= 1'b0;
      else if ((ex_mem_mem_read | ex_mem_mem_write) & misalign) mem_misalign_err <= 1'b1;
   end
`else
   assign store_ok     = ex_mem_mem_write;
   assign load_ok      = ex_mem_mem_read;
   assign wb_reg_write = ex_mem_reg_write;
`endif

   // Gating with RST keeps a store presented in the reset cycle out of the array.
   assign we = (store_ok && !RST) ? lane_we(ex_mem_load_mode, lane) : '0;

   always_comb begin
      case (ex_mem_load_mode)
         LM_WORD: wdata = ex_mem_rt;
         LM_HALF: wdata = {2{ex_mem_rt[15:0]}};
         default: wdata = {4{ex_mem_rt[7:0]}};
      endcase
   end

   data_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_data_mem (
      .CLK   (CLK),
      .we    (we),
      .addr  (word_idx),
      .wdata (wdata),
      .rdata (rdata)
   );

   always_comb begin
      byte_sel = 8'(rdata >> {lane, 3'b000});
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
      case (ex_mem_load_mode)
         LM_WORD: load_data = rdata;
         LM_HALF: load_data = {{16{half_sel[15]}}, half_sel};
         LM_BYTE: load_data = {{24{byte_sel[7]}}, byte_sel};
         default: load_data = {24'h0, byte_sel};
      endcase
      if (!load_ok) load_data = '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mem_wb_reg_write  <= 1'b0;
         mem_wb_mem_to_reg <= 1'b0;
         mem_wb_load_mode  <= '0;
         mem_wb_dest       <= '0;
         mem_wb_read_data  <= '0;
         mem_wb_alu_result <= '0;
      end else begin
         mem_wb_reg_write  <= wb_reg_write;
         mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
         mem_wb_load_mode  <= ex_mem_load_mode;
         mem_wb_dest       <= ex_mem_dest;
         mem_wb_read_data  <= load_data;
         mem_wb_alu_result <= ex_mem_alu_result;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors, expectations queued at issue.
// Exercises the trap port when MEM_STAGE_MISALIGN_TRAP_EN is defined.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ex_mem_zero, ex_mem_branch, ex_mem_reg_write, ex_mem_mem_write;
   logic        ex_mem_mem_read, ex_mem_mem_to_reg;
   logic [1:0]  ex_mem_load_mode;
   logic [4:0]  ex_mem_dest;
   logic [31:0] ex_mem_alu_result, ex_mem_rt, ex_mem_pc;
   logic        mem_if_pc_src;
   logic [31:0] mem_if_pc;
   logic        mem_wb_reg_write, mem_wb_mem_to_reg;
   logic [1:0]  mem_wb_load_mode;
   logic [4:0]  mem_wb_dest;
   logic [31:0] mem_wb_read_data, mem_wb_alu_result;
   logic        err_out;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  dest;
      logic        rw;
      logic        m2r;
      logic [1:0]  lm;
      logic        err;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_issued = 0;

   mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .ex_mem_zero       (ex_mem_zero),
      .ex_mem_branch     (ex_mem_branch),
      .ex_mem_reg_write  (ex_mem_reg_write),
      .ex_mem_mem_write  (ex_mem_mem_write),
      .ex_mem_mem_read   (ex_mem_mem_read),
      .ex_mem_mem_to_reg (ex_mem_mem_to_reg),
      .ex_mem_load_mode  (ex_mem_load_mode),
      .ex_mem_dest       (ex_mem_dest),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_rt         (ex_mem_rt),
      .ex_mem_pc         (ex_mem_pc),
      .mem_if_pc_src     (mem_if_pc_src),
      .mem_if_pc         (mem_if_pc),
      .mem_wb_reg_write  (mem_wb_reg_write),
      .mem_wb_mem_to_reg (mem_wb_mem_to_reg),
      .mem_wb_load_mode  (mem_wb_load_mode),
      .mem_wb_dest       (mem_wb_dest),
      .mem_wb_read_data  (mem_wb_read_data),
      .mem_wb_alu_result (mem_wb_alu_result)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      ,
      .mem_misalign_err  (err_out)
`endif
   );

`ifndef MEM_STAGE_MISALIGN_TRAP_EN
   assign err_out = 1'b0;
`endif

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[#%0d]: got %h expected %h", nm, id, act, exp);
      end
   endtask

   task automatic idle();
      ex_mem_zero = 0; ex_mem_branch = 0; ex_mem_reg_write = 0; ex_mem_mem_write = 0;
      ex_mem_mem_read = 0; ex_mem_mem_to_reg = 0; ex_mem_load_mode = 2'b00;
      ex_mem_dest = 5'd0; ex_mem_alu_result = 32'h0; ex_mem_rt = 32'h0; ex_mem_pc = 32'h0;
   endtask

   task automatic issue(input logic rw, input logic mw, input logic mr, input logic m2r,
                        input logic [1:0] lm, input logic [4:0] dst, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [31:0] exp_rd,
                        input logic exp_rw, input logic exp_err);
      exp_t e;
      @(negedge CLK);
      idle();
      ex_mem_reg_write = rw; ex_mem_mem_write = mw; ex_mem_mem_read = mr;
      ex_mem_mem_to_reg = m2r; ex_mem_load_mode = lm; ex_mem_dest = dst;
      ex_mem_alu_result = alu; ex_mem_rt = rt;
      e.rd = exp_rd; e.alu = alu; e.dest = dst; e.rw = exp_rw; e.m2r = m2r;
      e.lm = lm; e.err = exp_err; e.id = n_issued;
      n_issued++;
      sb.push_back(e);
   endtask

   task automatic chk_mem_wb_zero(input string nm);
      chk({nm, "_rw"},   0, 32'(mem_wb_reg_write),  32'h0);
      chk({nm, "_m2r"},  0, 32'(mem_wb_mem_to_reg), 32'h0);
      chk({nm, "_lm"},   0, 32'(mem_wb_load_mode),  32'h0);
      chk({nm, "_dest"}, 0, 32'(mem_wb_dest),       32'h0);
      chk({nm, "_rd"},   0, mem_wb_read_data,       32'h0);
      chk({nm, "_alu"},  0, mem_wb_alu_result,      32'h0);
   endtask

   // Monitor: every result lands one edge after its issue.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("read_data",  e.id, mem_wb_read_data,          e.rd);
            chk("alu_result", e.id, mem_wb_alu_result,         e.alu);
            chk("dest",       e.id, 32'(mem_wb_dest),          32'(e.dest));
            chk("reg_write",  e.id, 32'(mem_wb_reg_write),     32'(e.rw));
            chk("mem_to_reg", e.id, 32'(mem_wb_mem_to_reg),    32'(e.m2r));
            chk("load_mode",  e.id, 32'(mem_wb_load_mode),     32'(e.lm));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            chk("misalign_err", e.id, 32'(err_out), 32'(e.err));
`endif
         end
      end
   end

   initial begin
      idle();
      repeat (3) @(posedge CLK);
      #1;
      chk_mem_wb_zero("reset");
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      chk("reset_err", 0, 32'(err_out), 32'h0);
`endif
      @(negedge CLK);
      RST = 0;

      //     rw mw mr m2r mode   dst   alu            rt             exp_rd         erw err
      issue(0, 1, 0, 0, 2'b00, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          0, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd2, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1, 0);
      issue(1, 0, 1, 1, 2'b10, 5'd3, 32'h0000_0011, 32'h0,         32'hFFFF_FFBE, 1, 0);
      issue(1, 0, 1, 1, 2'b11, 5'd4, 32'h0000_0011, 32'h0,         32'h0000_00BE, 1, 0);
      issue(1, 0, 1, 1, 2'b01, 5'd5, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1, 0);
      issue(1, 0, 1, 1, 2'b01, 5'd6, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 1, 0);
      issue(0, 1, 0, 0, 2'b11, 5'd0, 32'h0000_0013, 32'hAAAA_AA55, 32'h0,          0, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd7, 32'h0000_0010, 32'h0,         32'h55AD_BEEF, 1, 0);
      issue(1, 0, 1, 1, 2'b10, 5'd8, 32'h0000_0013, 32'h0,         32'h0000_0055, 1, 0);
      issue(0, 1, 0, 0, 2'b00, 5'd0, 32'h0000_0020, 32'h0,         32'h0,          0, 0);
      issue(0, 1, 0, 0, 2'b01, 5'd0, 32'h0000_0022, 32'h1234_8001, 32'h0,          0, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd9, 32'h0000_0020, 32'h0,         32'h8001_0000, 1, 0);
      issue(1, 0, 1, 1, 2'b01, 5'd10, 32'h0000_0022, 32'h0,        32'hFFFF_8001, 1, 0);
      issue(1, 0, 1, 1, 2'b01, 5'd11, 32'h0000_0020, 32'h0,        32'h0,          1, 0);
      // read+write together returns pre-write data
      issue(1, 1, 1, 1, 2'b00, 5'd12, 32'h0000_0010, 32'h1122_3344, 32'h55AD_BEEF, 1, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd13, 32'h0000_0010, 32'h0,         32'h1122_3344, 1, 0);
      issue(1, 0, 0, 0, 2'b00, 5'd14, 32'h1234_5678, 32'h0,         32'h0,          1, 0);
      issue(0, 1, 0, 0, 2'b00, 5'd0, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,          0, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd15, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1, 0);
      issue(0, 1, 0, 0, 2'b00, 5'd0, 32'h0000_0004, 32'h0102_0304, 32'h0,          0, 0);
      issue(1, 0, 1, 1, 2'b00, 5'd16, 32'h0000_0010, 32'h0,         32'h1122_3344, 1, 0);

      // Branch resolution is combinational
      @(negedge CLK);
      idle();
      ex_mem_branch = 1; ex_mem_zero = 1; ex_mem_pc = 32'h0000_0040;
      #1;
      chk("pc_src_taken", 0, 32'(mem_if_pc_src), 32'h1);
      chk("if_pc",        0, mem_if_pc,          32'h0000_0040);
      ex_mem_zero = 0;
      #1;
      chk("pc_src_not_taken", 0, 32'(mem_if_pc_src), 32'h0);
      ex_mem_branch = 0; ex_mem_zero = 1;
      #1;
      chk("pc_src_no_branch", 0, 32'(mem_if_pc_src), 32'h0);

      issue(1, 0, 1, 1, 2'b00, 5'd17, 32'h0000_0004, 32'h0, 32'h0102_0304, 1, 0);

      // Reset mid-stream with a store pending: outputs clear, store dropped
      @(negedge CLK);
      idle();
      ex_mem_mem_write = 1; ex_mem_alu_result = 32'h0000_0404; ex_mem_rt = 32'hFFFF_FFFF;
      RST = 1;
      #1;
      chk_mem_wb_zero("mid_reset");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 0;
      idle();
      issue(1, 0, 1, 1, 2'b00, 5'd18, 32'h0000_0004, 32'h0, 32'h0102_0304, 1, 0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      issue(0, 1, 0, 0, 2'b00, 5'd0,  32'h0000_0012, 32'hFFFF_FFFF, 32'h0,          0, 1);
      issue(1, 0, 1, 1, 2'b00, 5'd19, 32'h0000_0010, 32'h0,         32'h1122_3344, 1, 1);
      issue(1, 0, 1, 1, 2'b01, 5'd20, 32'h0000_0011, 32'h0,         32'h0,          0, 1);
      issue(0, 1, 0, 0, 2'b01, 5'd0,  32'h0000_0011, 32'h0000_0000, 32'h0,          0, 1);
      issue(1, 0, 1, 1, 2'b00, 5'd21, 32'h0000_0010, 32'h0,         32'h1122_3344, 1, 1);
`endif

      @(negedge CLK);
      idle();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
      #2;
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expected results never observed, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
